// File: rtl/sfp_accbuf.sv
// Multi-pass per-lane saturating accumulator with activation and a valid/ready result stream.
// Optional SFP_LEAKY_EN: negative activated values become sum >>> LEAKY_SHIFT instead of 0.
module sfp_accbuf #(
    parameter int COL         = 8,
    parameter int BW          = 16,
    parameter int DEPTH       = 16,
    parameter int AW          = $clog2(DEPTH),
    parameter int LEAKY_SHIFT = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_start,
    input  logic [7:0]        cfg_npass,
    input  logic [AW:0]       cfg_len,
    input  logic              cfg_relu_en,
    input  logic              cfg_mode,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [AW-1:0]     in_addr,
    input  logic [COL*BW-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [AW-1:0]     out_addr,
    output logic [COL*BW-1:0] out_data,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    if (LEAKY_SHIFT < 0 || LEAKY_SHIFT >= BW) begin : g_bad_shift
        $error("LEAKY_SHIFT must lie in [0, BW-1]");
    end

    state_t              state_q, state_d;
    logic [7:0]          npass_q, npass_d;
    logic [7:0]          pass_cnt_q, pass_cnt_d;
    logic [AW:0]         len_q, len_d;
    logic                relu_q, relu_d;
    logic                mode_q, mode_d;
    logic                out_valid_q, out_valid_d;
    logic [AW-1:0]       out_addr_q, out_addr_d;
    logic [COL*BW-1:0]   out_data_q, out_data_d;
    logic                done_q, done_d;
    logic [COL*BW-1:0]   mem_q [DEPTH];

    logic [7:0]          npass_eff;
    logic                last_pass;
    logic                first_pass;
    logic                accept;
    logic                addr_ok;
    logic                end_beat;
    logic                mem_we;
    logic [COL*BW-1:0]   rd_data;
    logic [COL*BW-1:0]   sum_vec;
    logic [COL*BW-1:0]   act_vec;

    // OS bypass is a single pass; a zero pass count behaves as one pass.
    assign npass_eff  = (mode_q || npass_q == 8'd0) ? 8'd1 : npass_q;
    assign last_pass  = (pass_cnt_q == npass_eff - 8'd1);
    assign first_pass = (pass_cnt_q == 8'd0);
    assign in_ready   = (state_q == RUN) && (!last_pass || !out_valid_q || out_ready);
    assign accept     = in_valid && in_ready;
    assign addr_ok    = ({1'b0, in_addr} < len_q);
    assign end_beat   = accept && ({1'b0, in_addr} == len_q - 1'b1);
    assign mem_we     = accept && addr_ok && !last_pass;
    assign rd_data    = mem_q[in_addr];

    always_comb begin
        logic signed [BW-1:0] old_l, in_l, s_l, a_l;
        logic signed [BW:0]   wide;
        sum_vec = '0;
        act_vec = '0;
        for (int unsigned i = 0; i < COL; i++) begin
            old_l = rd_data[i*BW +: BW];
            in_l  = in_data[i*BW +: BW];
            wide  = {old_l[BW-1], old_l} + {in_l[BW-1], in_l};
            // Differing top two bits of the widened sum mean the lane overflowed.
            if (first_pass) begin
                s_l = in_l;
            end else if (wide[BW] != wide[BW-1]) begin
                s_l = wide[BW] ? {1'b1, {(BW-1){1'b0}}} : {1'b0, {(BW-1){1'b1}}};
            end else begin
                s_l = wide[BW-1:0];
            end
            a_l = s_l;
            if (relu_q && !mode_q && s_l[BW-1]) begin
`ifdef SFP_LEAKY_EN
                a_l = s_l >>> LEAKY_SHIFT;
`else
                a_l = '0;
`endif
            end
            sum_vec[i*BW +: BW] = s_l;
            act_vec[i*BW +: BW] = a_l;
        end
    end

    always_comb begin
        state_d     = state_q;
        npass_d     = npass_q;
        pass_cnt_d  = pass_cnt_q;
        len_d       = len_q;
        relu_d      = relu_q;
        mode_d      = mode_q;
        out_valid_d = out_valid_q;
        out_addr_d  = out_addr_q;
        out_data_d  = out_data_q;
        done_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (cfg_start) begin
                    npass_d    = cfg_npass;
                    len_d      = cfg_len;
                    relu_d     = cfg_relu_en;
                    mode_d     = cfg_mode;
                    pass_cnt_d = '0;
                    state_d    = RUN;
                end
            end
            RUN: begin
                if (end_beat) begin
                    pass_cnt_d = pass_cnt_q + 8'd1;
                    if (last_pass) state_d = FLUSH;
                end
            end
            FLUSH: begin
                if (!out_valid_q || out_ready) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (out_valid_q && out_ready) out_valid_d = 1'b0;
        if (accept && addr_ok && last_pass) begin
            out_valid_d = 1'b1;
            out_addr_d  = in_addr;
            out_data_d  = act_vec;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            npass_q     <= '0;
            pass_cnt_q  <= '0;
            len_q       <= '0;
            relu_q      <= 1'b0;
            mode_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_addr_q  <= '0;
            out_data_q  <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            npass_q     <= npass_d;
            pass_cnt_q  <= pass_cnt_d;
            len_q       <= len_d;
            relu_q      <= relu_d;
            mode_q      <= mode_d;
            out_valid_q <= out_valid_d;
            out_addr_q  <= out_addr_d;
            out_data_q  <= out_data_d;
            done_q      <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem_q[in_addr] <= sum_vec;
    end

    assign out_valid = out_valid_q;
    assign out_addr  = out_addr_q;
    assign out_data  = out_data_q;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;

endmodule

// File: tb/tb_sfp_accbuf.sv
// Directed bench for sfp_accbuf with a queue scoreboard fed by a behavioural accumulator model.
module tb_sfp_accbuf;

    localparam int COL   = 8;
    localparam int BW    = 16;
    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int DW    = COL * BW;

    logic          clk = 1'b0;
    logic          reset;
    logic          cfg_start;
    logic [7:0]    cfg_npass;
    logic [AW:0]   cfg_len;
    logic          cfg_relu_en;
    logic          cfg_mode;
    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] in_addr;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] out_addr;
    logic [DW-1:0] out_data;
    logic          busy;
    logic          done;

    sfp_accbuf #(.COL(COL), .BW(BW), .DEPTH(DEPTH), .AW(AW), .LEAKY_SHIFT(3)) dut (
        .clk(clk), .reset(reset), .cfg_start(cfg_start), .cfg_npass(cfg_npass),
        .cfg_len(cfg_len), .cfg_relu_en(cfg_relu_en), .cfg_mode(cfg_mode),
        .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr), .out_data(out_data),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } exp_t;

    exp_t          sb[$];
    int            n_assert = 0;
    int            n_fail   = 0;
    int            done_cnt = 0;
    logic [DW-1:0] out_by_addr [DEPTH];
    int            tb_buf [DEPTH][COL];
    int            m_pass, m_npe, m_len;
    bit            m_relu, m_mode;
    logic          held_v = 1'b0;
    logic [AW-1:0] held_a;
    logic [DW-1:0] held_d;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (!reset) begin
            if (held_v && out_valid) begin
                chk("hold_addr", out_addr, held_a);
                chk("hold_data", out_data, held_d);
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("spurious_out", out_valid, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("out_addr", out_addr, e.a);
                    chk("out_data", out_data, e.d);
                    out_by_addr[out_addr] = out_data;
                end
            end
            held_v = out_valid && !out_ready;
            held_a = out_addr;
            held_d = out_data;
        end else begin
            held_v = 1'b0;
        end
    end

    task automatic start(input int np, input int len, input bit relu, input bit mode);
        cfg_npass = np[7:0]; cfg_len = len[AW:0]; cfg_relu_en = relu; cfg_mode = mode;
        cfg_start = 1'b1;
        @(posedge clk); #1;
        cfg_start = 1'b0;
        chk("busy_after_start", busy, 1);
        m_pass = 0; m_len = len; m_relu = relu; m_mode = mode;
        m_npe = (mode || np == 0) ? 1 : np;
    endtask

    task automatic beat(input int a, input logic [DW-1:0] d);
        logic [DW-1:0] e;
        bit            lastp, vld;
        int            n;
        lastp = (m_pass == m_npe - 1);
        vld   = (a < m_len);
        e     = '0;
        if (vld) begin
            for (int i = 0; i < COL; i++) begin
                int x, s;
                x = $signed(d[i*BW +: BW]);
                s = (m_pass == 0) ? x : sat(tb_buf[a][i] + x);
                if (lastp) begin
                    if (m_relu && !m_mode && s < 0) begin
`ifdef SFP_LEAKY_EN
                        s = s >>> 3;
`else
                        s = 0;
`endif
                    end
                    e[i*BW +: BW] = s[BW-1:0];
                end else begin
                    tb_buf[a][i] = s;
                end
            end
            if (lastp) sb.push_back({a[AW-1:0], e});
        end
        in_valid = 1'b1; in_addr = a[AW-1:0]; in_data = d;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("in_ready_timeout", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (lastp && vld) begin
            chk("latency_valid", out_valid, 1);
            chk("latency_addr", out_addr, a[AW-1:0]);
        end
        if (a == m_len - 1) m_pass++;
    endtask

    task automatic wait_idle(input int done_before);
        int n;
        n = 0;
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("return_idle", busy, 0);
        @(negedge clk);
        chk("done_pulses", done_cnt - done_before, 1);
        chk("scoreboard_empty", sb.size(), 0);
        @(posedge clk); #1;
    endtask

    function automatic logic [DW-1:0] lanes(input int base, input int step);
        logic [DW-1:0] d;
        int            v;
        for (int i = 0; i < COL; i++) begin
            v = base + i * step;
            d[i*BW +: BW] = v[BW-1:0];
        end
        return d;
    endfunction

    initial begin
        int            d0;
        logic [DW-1:0] d;
        logic [BW-1:0] lane;

        reset = 1'b1; cfg_start = 0; cfg_npass = 0; cfg_len = 0; cfg_relu_en = 0; cfg_mode = 0;
        in_valid = 0; in_addr = 0; in_data = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, '0);
        chk("rst_out_addr", out_addr, '0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_in_ready", in_ready, 0);
        @(posedge clk); #1;

        // Three-pass accumulation, lane0 = +5 per beat; an out-of-range beat in every pass.
        d0 = done_cnt;
        start(3, 4, 0, 0);
        for (int p = 0; p < 3; p++) begin
            for (int a = 0; a < 4; a++) begin
                d = lanes(5, 100 * (p + 1) - 37);
                beat(a, d);
                if (a == 1) beat(9, lanes(-1000, 7));
            end
        end
        wait_idle(d0);
        for (int a = 0; a < 4; a++) begin
            d = out_by_addr[a];
            lane = d[BW-1:0];
            chk("t1_lane0_15", lane, 16'd15);
        end

        // Two-pass ReLU: lane1 -7 then +2.
        d0 = done_cnt;
        start(2, 1, 1, 0);
        d = '0; d[2*BW-1:BW] = 16'hFFF9; beat(0, d);
        d = '0; d[2*BW-1:BW] = 16'd2;    beat(0, d);
        wait_idle(d0);
        d = out_by_addr[0];
        lane = d[2*BW-1:BW];
`ifdef SFP_LEAKY_EN
        chk("t2_relu_lane1", lane, 16'hFFFF);
`else
        chk("t2_relu_lane1", lane, 16'h0000);
`endif

        // Saturation in both directions.
        d0 = done_cnt;
        start(2, 2, 0, 0);
        for (int p = 0; p < 2; p++) begin
            d = '0; d[BW-1:0] = 16'h7000; beat(0, d);
            d = '0; d[BW-1:0] = 16'h9000; beat(1, d);
        end
        wait_idle(d0);
        d = out_by_addr[0]; lane = d[BW-1:0];
        chk("t3_sat_pos", lane, 16'h7FFF);
        d = out_by_addr[1]; lane = d[BW-1:0];
        chk("t3_sat_neg", lane, 16'h8000);

        // Backpressure: downstream stalls five cycles while a second beat waits.
        d0 = done_cnt;
        start(1, 4, 0, 0);
        out_ready = 1'b0;
        beat(0, lanes(11, 3));
        fork
            beat(1, lanes(-22, 5));
            begin
                repeat (5) begin
                    @(negedge clk);
                    chk("bp_in_ready_low", in_ready, 0);
                end
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        beat(2, lanes(33, -4));
        beat(3, lanes(44, 9));
        wait_idle(d0);

        // OS bypass: negative data passes through unchanged despite relu_en and npass=5.
        d0 = done_cnt;
        start(5, 8, 1, 1);
        for (int a = 0; a < 8; a++) begin
            d = lanes(-100 * (a + 1), -13);
            beat(a, d);
            chk("os_passthrough", out_data, d);
        end
        wait_idle(d0);

        // Reset with a pending output: dropped, no done pulse, then a clean run.
        start(1, 4, 0, 0);
        out_ready = 1'b0;
        beat(0, lanes(7, 1));
        d0 = done_cnt;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        sb.delete();
        chk("rst_mid_out_valid", out_valid, 0);
        chk("rst_mid_busy", busy, 0);
        @(negedge clk);
        chk("rst_mid_no_done", done_cnt - d0, 0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        d0 = done_cnt;
        start(1, 2, 1, 0);
        beat(0, lanes(-3, 2));
        beat(1, lanes(4, -2));
        wait_idle(d0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/sfp_accbuf.md
Name: sfp_accbuf

Overview:
Next-generation special-function processor at the output of the systolic array. It accumulates per-column partial sums across multiple kernel passes in an internal buffer of DEPTH entries, with per-lane saturating arithmetic. On the final pass it applies ReLU and emits results over a valid/ready stream toward the output SRAM. OS mode bypasses accumulation and activation.

Parameters:
COL, 8, number of lanes (array columns)
BW, 16, signed psum width per lane
DEPTH, 16, accumulation buffer entries (output positions per pass)
AW, $clog2(DEPTH), address width
LEAKY_SHIFT, 3, right-shift amount for leaky ReLU (used only with SFP_LEAKY_EN)

Ports:
clk  input  1  clock
reset  input  1  synchronous active-high reset
cfg_start  input  1  pulse; latches cfg_* when IDLE, ignored otherwise
cfg_npass  input  8  passes to accumulate (0 treated as 1)
cfg_len  input  AW+1  addresses per pass, 1..DEPTH
cfg_relu_en  input  1  enable activation on final pass
cfg_mode  input  1  0=WS accumulate, 1=OS bypass
in_valid  input  1  input beat valid
in_ready  output  1  input beat accepted when in_valid&&in_ready
in_addr  input  AW  buffer address of beat
in_data  input  COL*BW  packed signed psums, lane i at [BW*(i+1)-1:BW*i]
out_valid  output  1  result valid
out_ready  input  1  downstream accept
out_addr  output  AW  address of result
out_data  output  COL*BW  activated result
busy  output  1  state != IDLE
done  output  1  one-cycle pulse on FLUSH->IDLE

Behaviour:
- Reset: state IDLE, pass_cnt=0, out_valid=0, out_data=0, out_addr=0, done=0, latched cfg=0. Buffer contents not reset.
- FSM IDLE -> RUN on cfg_start; RUN -> FLUSH on acceptance of beat with in_addr==cfg_len-1 in last pass; FLUSH -> IDLE when out_valid==0, or out_valid&&out_ready that cycle; done=1 on that transition.
- OS mode: effective npass=1, no activation; every beat forwarded unchanged.
- pass_cnt increments on acceptance of the beat with in_addr==cfg_len-1; last_pass = (pass_cnt==npass-1).
- Per lane: sum = first_pass ? in : sat(buf[addr]+in); sat clamps to [-2^(BW-1), 2^(BW-1)-1] (no wrap).
- Non-last pass: buf[addr]<=sum, no output produced.
- Last pass: out_data<=act(sum), out_addr<=in_addr, out_valid<=1, buffer not written.
- act: relu_en && sum<0 -> 0, else sum.
- in_ready = (state==RUN) && (!last_pass || !out_valid || out_ready); 1-entry output register, zero bubble under continuous out_ready.
- Output latency: 1 cycle from accepted final-pass beat to out_valid.
- out_valid/out_addr/out_data held stable while out_valid && !out_ready.
- in_addr >= cfg_len: beat accepted, buffer/output unaffected, counted as nothing.
- Reset mid-operation: immediate return to IDLE, pending output dropped, no done pulse.

Optional Feature:
SFP_LEAKY_EN. Defined: negative activated values become sum >>> LEAKY_SHIFT (arithmetic) instead of 0. Undefined: plain ReLU, LEAKY_SHIFT unused.

Test Plan:
- WS, npass=3, len=4, relu off; each beat lane0=+5 -> out lane0=15 at addr 0..3, done pulse after 4th output.
- WS, npass=2, relu on; lane1 beats -7 then +2 -> out lane1=0; with SFP_LEAKY_EN -> -5>>>3 = -1.
- Saturation: BW=16, two passes of 0x7000 -> 0x7FFF; two passes of 0x9000 -> 0x8000 (relu off).
- Backpressure: out_ready low 5 cycles during last pass -> in_ready low, out_data/out_addr stable, no beat lost; release -> sequence continues.
- OS mode: 8 beats with negative data, relu_en=1 -> out_data equals in_data, 1-cycle latency, no buffer read.
- Reset asserted mid-RUN with out_valid=1 -> next cycle out_valid=0, busy=0, no done; new cfg_start runs cleanly.
